// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the read-address arbiter: FSM states, decode results, window size.
// The AXI field-width macros are defined here when they are not already provided.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        DEC_S0  = 2'd0,
        DEC_S1  = 2'd1,
        DEC_DEF = 2'd2
    } dec_t;

    localparam logic [31:0] WIN_SIZE = 32'h0001_0000;

    // Saturating-free up/down step; a completion at zero is ignored.
    function automatic logic [1:0] outs_update(input logic [1:0] cnt,
                                               input logic       inc,
                                               input logic       dec);
        logic [1:0] r;
        r = cnt;
        if (inc && !(dec && cnt != 2'd0)) begin
            r = cnt + 2'd1;
        end else if (!inc && dec && cnt != 2'd0) begin
            r = cnt - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational read-address decoder: maps an address onto S0, S1 or the default (DECERR) slave.
module axi_addr_decode
    import axi_arb_pkg::*;
#(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S1_BASE = 32'h0001_0000
) (
    input  logic [31:0] addr,
    output logic [1:0]  dec
);

    logic [31:0] off0;
    logic [31:0] off1;

    // Unsigned offset compare also rejects addresses below the base (they wrap high).
    always_comb begin
        off0 = addr - S0_BASE;
        off1 = addr - S1_BASE;
        dec  = DEC_DEF;
        if (off0 < WIN_SIZE) begin
            dec = DEC_S0;
        end else if (off1 < WIN_SIZE) begin
            dec = DEC_S1;
        end
    end

endmodule

// File: rtl/axi_ar_arbiter.sv
// AR-channel arbiter/decoder for the 2-master / 2-slave bridge, with per-master outstanding caps.
// Define AR_FIXED_PRIO_EN for fixed priority (M1 wins ties); otherwise round-robin.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_ar_arbiter
    import axi_arb_pkg::*;
#(
    parameter int          MAX_OUTS = 1,
    parameter logic [31:0] S0_BASE  = 32'h0000_0000,
    parameter logic [31:0] S1_BASE  = 32'h0001_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`AXI_ID_BITS-1:0]    ARID_M0,
    input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M0,
    input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M0,
    input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M0,
    input  logic [1:0]                 ARBURST_M0,
    input  logic                       ARVALID_M0,
    output logic                       ARREADY_M0,
    input  logic [`AXI_ID_BITS-1:0]    ARID_M1,
    input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M1,
    input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M1,
    input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M1,
    input  logic [1:0]                 ARBURST_M1,
    input  logic                       ARVALID_M1,
    output logic                       ARREADY_M1,
    output logic [`AXI_IDS_BITS-1:0]   ARID_S,
    output logic [`AXI_ADDR_BITS-1:0]  ARADDR_S,
    output logic [`AXI_LEN_BITS-1:0]   ARLEN_S,
    output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S,
    output logic [1:0]                 ARBURST_S,
    output logic                       ARVALID_S0,
    input  logic                       ARREADY_S0,
    output logic                       ARVALID_S1,
    input  logic                       ARREADY_S1,
    input  logic                       rdone_m0,
    input  logic                       rdone_m1,
    output logic                       getaddr_default,
    output logic                       master_signal,
    output logic                       dbg_state
);

    // Handshake rule: an AR transfers on any cycle where the granted master's ARREADY is high
    // while in GRANT; ARVALID_Sx is driven from the grant, not re-gated by the master's ARVALID.

    localparam logic [1:0] MAX_C = 2'(MAX_OUTS);

    arb_state_t state, state_next;
    logic       grant, grant_next;
    logic       last_winner, last_next;
    logic [1:0] outs0, outs1, outs0_next, outs1_next;

    logic [`AXI_ID_BITS-1:0]   sel_id;
    logic [`AXI_ADDR_BITS-1:0] sel_addr;
    logic [`AXI_LEN_BITS-1:0]  sel_len;
    logic [`AXI_SIZE_BITS-1:0] sel_size;
    logic [1:0]                sel_burst;
    logic [1:0]                dec_raw;
    dec_t                      dec;
    logic                      slave_rdy;
    logic                      hs;
    logic                      el0, el1;

    assign sel_id    = grant ? ARID_M1    : ARID_M0;
    assign sel_addr  = grant ? ARADDR_M1  : ARADDR_M0;
    assign sel_len   = grant ? ARLEN_M1   : ARLEN_M0;
    assign sel_size  = grant ? ARSIZE_M1  : ARSIZE_M0;
    assign sel_burst = grant ? ARBURST_M1 : ARBURST_M0;

    axi_addr_decode #(
        .S0_BASE (S0_BASE),
        .S1_BASE (S1_BASE)
    ) u_dec (
        .addr (sel_addr),
        .dec  (dec_raw)
    );

    assign dec       = dec_t'(dec_raw);
    assign slave_rdy = (dec == DEC_S0) ? ARREADY_S0 :
                       (dec == DEC_S1) ? ARREADY_S1 : 1'b1;
    assign hs        = (state == GRANT) && slave_rdy;
    assign el0       = ARVALID_M0 && (outs0 < MAX_C);
    assign el1       = ARVALID_M1 && (outs1 < MAX_C);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_winner <= 1'b1;
            outs0       <= 2'd0;
            outs1       <= 2'd0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            last_winner <= last_next;
            outs0       <= outs0_next;
            outs1       <= outs1_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last_winner;
        outs0_next = outs_update(outs0, hs && !grant, rdone_m0);
        outs1_next = outs_update(outs1, hs && grant, rdone_m1);
        case (state)
            IDLE: begin
                if (el0 && el1) begin
`ifdef AR_FIXED_PRIO_EN
                    grant_next = 1'b1;
`else
                    grant_next = ~last_winner;
`endif
                    state_next = GRANT;
                end else if (el0) begin
                    grant_next = 1'b0;
                    state_next = GRANT;
                end else if (el1) begin
                    grant_next = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (hs) begin
                    state_next = IDLE;
                    last_next  = grant;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ARID_S          = '0;
        ARADDR_S        = '0;
        ARLEN_S         = '0;
        ARSIZE_S        = '0;
        ARBURST_S       = '0;
        ARVALID_S0      = 1'b0;
        ARVALID_S1      = 1'b0;
        ARREADY_M0      = 1'b0;
        ARREADY_M1      = 1'b0;
        getaddr_default = 1'b0;
        master_signal   = 1'b0;
        if (state == GRANT) begin
            ARID_S          = {{(`AXI_IDS_BITS-`AXI_ID_BITS-1){1'b0}}, grant, sel_id};
            ARADDR_S        = sel_addr;
            ARLEN_S         = sel_len;
            ARSIZE_S        = sel_size;
            ARBURST_S       = sel_burst;
            ARVALID_S0      = (dec == DEC_S0);
            ARVALID_S1      = (dec == DEC_S1);
            ARREADY_M0      = !grant && slave_rdy;
            ARREADY_M1      = grant && slave_rdy;
            getaddr_default = (dec == DEC_DEF);
            master_signal   = grant && (dec == DEC_DEF);
        end
    end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed bench for axi_ar_arbiter: decode, round-robin, outstanding caps, stalls and reset.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module tb_axi_ar_arbiter;

    logic                       clk;
    logic                       rst;
    logic [`AXI_ID_BITS-1:0]    ARID_M0, ARID_M1;
    logic [`AXI_ADDR_BITS-1:0]  ARADDR_M0, ARADDR_M1;
    logic [`AXI_LEN_BITS-1:0]   ARLEN_M0, ARLEN_M1;
    logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]                 ARBURST_M0, ARBURST_M1;
    logic                       ARVALID_M0, ARVALID_M1;
    logic                       ARREADY_M0, ARREADY_M1;
    logic [`AXI_IDS_BITS-1:0]   ARID_S;
    logic [`AXI_ADDR_BITS-1:0]  ARADDR_S;
    logic [`AXI_LEN_BITS-1:0]   ARLEN_S;
    logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S;
    logic [1:0]                 ARBURST_S;
    logic                       ARVALID_S0, ARVALID_S1;
    logic                       ARREADY_S0, ARREADY_S1;
    logic                       rdone_m0, rdone_m1;
    logic                       getaddr_default, master_signal;
    logic                       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_win [3];

    axi_ar_arbiter dut (
        .clk(clk), .rst(rst),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
        .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0),
        .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1),
        .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S0(ARVALID_S0), .ARREADY_S0(ARREADY_S0),
        .ARVALID_S1(ARVALID_S1), .ARREADY_S1(ARREADY_S1),
        .rdone_m0(rdone_m0), .rdone_m1(rdone_m1),
        .getaddr_default(getaddr_default), .master_signal(master_signal),
        .dbg_state(dbg_state)
    );

    // Clock and reset-time defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m0(input logic v, input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        ARVALID_M0 = v; ARID_M0 = id; ARADDR_M0 = a; ARLEN_M0 = len;
        ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
    endtask

    task automatic drive_m1(input logic v, input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        ARVALID_M1 = v; ARID_M1 = id; ARADDR_M1 = a; ARLEN_M1 = len;
        ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'b01;
    endtask

    task automatic pulse_rdone(input logic r0, input logic r1);
        rdone_m0 = r0; rdone_m1 = r1;
        tick();
        rdone_m0 = 1'b0; rdone_m1 = 1'b0;
    endtask

    initial begin
`ifdef AR_FIXED_PRIO_EN
        exp_win[0] = 1'b1; exp_win[1] = 1'b1; exp_win[2] = 1'b1;
`else
        exp_win[0] = 1'b1; exp_win[1] = 1'b0; exp_win[2] = 1'b1;
`endif
        rst = 1'b1;
        drive_m0(1'b0, 4'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 4'h0, 32'h0, 4'h0);
        ARREADY_S0 = 1'b1; ARREADY_S1 = 1'b1;
        rdone_m0 = 1'b0; rdone_m1 = 1'b0;
        tick(); tick();
        rst = 1'b0;

        check_eq("rst_state", 32'(dbg_state), 32'd0);
        check_eq("rst_rdy", {30'd0, ARREADY_M1, ARREADY_M0}, 32'd0);
        check_eq("rst_vs", {30'd0, ARVALID_S1, ARVALID_S0}, 32'd0);
        check_eq("rst_def", {30'd0, master_signal, getaddr_default}, 32'd0);
        check_eq("rst_id", 32'(ARID_S), 32'd0);

        // M0 -> S0, immediate ready
        drive_m0(1'b1, 4'h3, 32'h0000_0100, 4'h2);
        check_eq("t1_idle_vs0", 32'(ARVALID_S0), 32'd0);
        tick();
        check_eq("t1_vs0", 32'(ARVALID_S0), 32'd1);
        check_eq("t1_vs1", 32'(ARVALID_S1), 32'd0);
        check_eq("t1_rdy_m0", 32'(ARREADY_M0), 32'd1);
        check_eq("t1_rdy_m1", 32'(ARREADY_M1), 32'd0);
        check_eq("t1_id", 32'(ARID_S), 32'h03);
        check_eq("t1_addr", ARADDR_S, 32'h0000_0100);
        check_eq("t1_len", 32'(ARLEN_S), 32'd2);
        check_eq("t1_size", 32'(ARSIZE_S), 32'd2);
        tick();
        check_eq("t1_turnaround", 32'(dbg_state), 32'd0);

        // M0 capped at one outstanding; M1 still wins
        tick();
        check_eq("cap_m0_blocked", 32'(ARVALID_S0), 32'd0);
        drive_m1(1'b1, 4'h5, 32'h0001_0040, 4'h1);
        tick();
        check_eq("cap_m1_vs1", 32'(ARVALID_S1), 32'd1);
        check_eq("cap_m1_id", 32'(ARID_S), 32'h15);
        check_eq("cap_m1_rdy", {30'd0, ARREADY_M1, ARREADY_M0}, 32'd2);
        tick();
        drive_m1(1'b0, 4'h0, 32'h0, 4'h0);
        pulse_rdone(1'b1, 1'b1);
        check_eq("cap_m0_not_yet", 32'(ARVALID_S0), 32'd0);
        tick();
        check_eq("cap_m0_unblocked", 32'(ARVALID_S0), 32'd1);
        tick();
        drive_m0(1'b0, 4'h0, 32'h0, 4'h0);
        pulse_rdone(1'b1, 1'b0);
        // Completion at zero must be ignored
        pulse_rdone(1'b1, 1'b1);

        // Arbitration between simultaneous requests
        for (int r = 0; r < 3; r++) begin
            drive_m0(1'b1, 4'h1, 32'h0000_0200, 4'h0);
            drive_m1(1'b1, 4'h2, 32'h0001_0000, 4'h0);
            tick();
            check_eq($sformatf("arb%0d_winner", r), 32'(ARID_S[`AXI_ID_BITS]), 32'(exp_win[r]));
            check_eq($sformatf("arb%0d_vs", r), {30'd0, ARVALID_S1, ARVALID_S0},
                     exp_win[r] ? 32'd2 : 32'd1);
            tick();
            drive_m0(1'b0, 4'h0, 32'h0, 4'h0);
            drive_m1(1'b0, 4'h0, 32'h0, 4'h0);
            pulse_rdone(!exp_win[r], exp_win[r]);
        end

        // M1 to an unmapped address: default slave
        drive_m1(1'b1, 4'h7, 32'h0002_0000, 4'h3);
        tick();
        check_eq("def_vs", {30'd0, ARVALID_S1, ARVALID_S0}, 32'd0);
        check_eq("def_rdy_m1", 32'(ARREADY_M1), 32'd1);
        check_eq("def_pulse", 32'(getaddr_default), 32'd1);
        check_eq("def_master", 32'(master_signal), 32'd1);
        tick();
        check_eq("def_rdy_after", 32'(ARREADY_M1), 32'd0);
        check_eq("def_pulse_after", 32'(getaddr_default), 32'd0);
        drive_m1(1'b0, 4'h0, 32'h0, 4'h0);
        pulse_rdone(1'b0, 1'b1);

        // S1 stall at top of its window, with M1 waiting for S0
        ARREADY_S1 = 1'b0;
        ARREADY_S0 = 1'b0;
        drive_m0(1'b1, 4'hA, 32'h0001_FFFF, 4'h7);
        tick();
        drive_m1(1'b1, 4'h4, 32'h0000_0010, 4'h0);
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("stall%0d_vs", c), {30'd0, ARVALID_S1, ARVALID_S0}, 32'd2);
            check_eq($sformatf("stall%0d_addr", c), ARADDR_S, 32'h0001_FFFF);
            check_eq($sformatf("stall%0d_id", c), 32'(ARID_S), 32'h0A);
            check_eq($sformatf("stall%0d_rdy", c), {30'd0, ARREADY_M1, ARREADY_M0}, 32'd0);
            tick();
        end
        ARREADY_S1 = 1'b1;
        #1;
        check_eq("stall_release_rdy", 32'(ARREADY_M0), 32'd1);
        tick();
        drive_m0(1'b0, 4'h0, 32'h0, 4'h0);
        check_eq("stall_turnaround", {30'd0, ARVALID_S1, ARVALID_S0}, 32'd0);
        tick();
        check_eq("pre_rst_m1_grant", 32'(ARID_S), 32'h14);
        check_eq("pre_rst_vs0", 32'(ARVALID_S0), 32'd1);

        // Reset while M1 holds the grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_m1(1'b0, 4'h0, 32'h0, 4'h0);
        check_eq("midrst_state", 32'(dbg_state), 32'd0);
        check_eq("midrst_vs", {30'd0, ARVALID_S1, ARVALID_S0}, 32'd0);
        check_eq("midrst_rdy", {30'd0, ARREADY_M1, ARREADY_M0}, 32'd0);
        check_eq("midrst_id", 32'(ARID_S), 32'd0);
        ARREADY_S0 = 1'b1;
        drive_m0(1'b1, 4'h6, 32'h0000_0010, 4'h0);
        tick();
        check_eq("post_rst_m0_grant", 32'(ARID_S), 32'h06);
        check_eq("post_rst_vs0", 32'(ARVALID_S0), 32'd1);
        tick();
        drive_m0(1'b0, 4'h0, 32'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
